// File: rtl/edge_pix_pack_if.sv
// edge_pix_pack_if: bundles the 1-bit edge-pixel input stream and the
// packed-word output handshake of edge_pix_pack.
//   din/din_vld/din_sop/din_eop : pixel stream from the Sobel stage (no backpressure)
//   dout/dout_sop/dout_eop      : packed word and its frame markers
//   dout_vld/dout_rdy           : valid/ready handshake to the frame-buffer writer
// Modports: slave = the packer, master = the surrounding environment.
interface edge_pix_pack_if #(
    parameter int WORD_W = 16
);
    logic              din;
    logic              din_vld;
    logic              din_sop;
    logic              din_eop;
    logic [WORD_W-1:0] dout;
    logic              dout_vld;
    logic              dout_rdy;
    logic              dout_sop;
    logic              dout_eop;

    modport slave (
        input  din, din_vld, din_sop, din_eop, dout_rdy,
        output dout, dout_vld, dout_sop, dout_eop
    );

    modport master (
        output din, din_vld, din_sop, din_eop, dout_rdy,
        input  dout, dout_vld, dout_sop, dout_eop
    );
endinterface

// File: rtl/edge_pix_pack.sv
// edge_pix_pack: packs a raster-order 1-bit edge-pixel stream into WORD_W-bit
// words (first pixel in the MSB), tags them with frame start/end flags and
// queues them in a FIFO_DEPTH-word first-word-fall-through FIFO for the
// frame-buffer writer.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bus (slave) : pixel stream in, packed words out (valid/ready)
//   frame_done  : one-cycle pulse in the cycle after each accepted eop beat
//   err_frm     : sticky framing error (stray pixel, sop inside a frame,
//                 pixel count != FRAME_PIX at eop)
//   err_ovf     : sticky FIFO overflow (word dropped)
//   clr_err     : clears both error flags; a coinciding error event wins
// Build option: define PIX_INVERT_EN to invert pixels before packing
// (pad bits then become 1 instead of 0).
module edge_pix_pack #(
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int FRAME_PIX  = 307200
) (
    input  logic           clk,
    input  logic           rst,
    edge_pix_pack_if.slave bus,
    output logic           frame_done,
    output logic           err_frm,
    output logic           err_ovf,
    input  logic           clr_err
);
    localparam int IW = $clog2(WORD_W);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = WORD_W + 2;   // FIFO entry: {word, sop, eop}

`ifdef PIX_INVERT_EN
    localparam logic PAD = 1'b1;
`else
    localparam logic PAD = 1'b0;
`endif

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                           state_q, state_n;
    logic [WORD_W-1:0]                sreg_q, sreg_n;
    logic [IW-1:0]                    idx_q, idx_n;
    logic [23:0]                      pix_q, pix_n;
    logic                             first_q, first_n;
    logic [FIFO_DEPTH-1:0][SW-1:0]    slot_q, slot_n;
    logic [CW-1:0]                    cnt_q, cnt_n;
    logic                             vld_q;
    logic                             done_q, done_n;
    logic                             frm_q, ovf_q;

    logic              pix, take, push, frm_evt, first_cur;
    logic [WORD_W-1:0] base, word;
    logic [IW-1:0]     idx_cur;
    logic [23:0]       cnt_cur;
    logic [SW-1:0]     push_word;

    // Inverting option folds into a XOR: the pad value equals the invert bit.
    assign pix = bus.din ^ PAD;

    // Packer FSM: next state, shift register and push request.
    // The shift register is preloaded with pad bits at each word start, so an
    // eop on a partial word pushes it as-is with the LSBs already padded.
    always_comb begin
        state_n   = state_q;
        sreg_n    = sreg_q;
        idx_n     = idx_q;
        pix_n     = pix_q;
        first_n   = first_q;
        done_n    = 1'b0;
        frm_evt   = 1'b0;
        push      = 1'b0;
        push_word = '0;
        take      = 1'b0;
        base      = sreg_q;
        word      = sreg_q;
        idx_cur   = idx_q;
        cnt_cur   = pix_q;
        first_cur = first_q;

        if (bus.din_vld) begin
            if (bus.din_sop) begin
                // sop always (re)starts a frame; inside a frame it is an error
                frm_evt   = (state_q == ACTIVE);
                take      = 1'b1;
                base      = {WORD_W{PAD}};
                idx_cur   = '0;
                cnt_cur   = 24'd1;
                first_cur = 1'b1;
            end else if (state_q == ACTIVE) begin
                take      = 1'b1;
                base      = sreg_q;
                idx_cur   = idx_q;
                cnt_cur   = (pix_q == 24'hFF_FFFF) ? pix_q : pix_q + 24'd1;
                first_cur = first_q;
            end else begin
                frm_evt = 1'b1;     // pixel outside a frame is dropped
            end

            if (take) begin
                word           = base;
                word[~idx_cur] = pix;   // bit WORD_W-1-k for power-of-two WORD_W
                pix_n          = cnt_cur;
                state_n        = ACTIVE;
                if (idx_cur == '1 || bus.din_eop) begin
                    push      = 1'b1;
                    push_word = {word, first_cur, bus.din_eop};
                    sreg_n    = {WORD_W{PAD}};
                    idx_n     = '0;
                    first_n   = 1'b0;
                    if (bus.din_eop) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        if (cnt_cur != 24'(FRAME_PIX))
                            frm_evt = 1'b1;
                    end
                end else begin
                    sreg_n  = word;
                    idx_n   = idx_cur + 1'b1;
                    first_n = first_cur;
                end
            end
        end
    end

    // Shift-register FIFO: slot 0 is the head and drives the outputs directly,
    // so dout and its flags come straight from flops and hold while stalled.
    logic          pop, full, do_push, ovf_evt;
    logic [AW-1:0] wr_idx;

    always_comb begin
        pop     = vld_q & bus.dout_rdy;
        full    = (cnt_q == CW'(FIFO_DEPTH));
        do_push = push & (~full | pop);
        ovf_evt = push & full & ~pop;
        wr_idx  = AW'(pop ? cnt_q - 1'b1 : cnt_q);
        slot_n  = pop ? (slot_q >> SW) : slot_q;
        if (do_push)
            slot_n[wr_idx] = push_word;
        cnt_n = cnt_q + CW'(do_push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            idx_q   <= '0;
            pix_q   <= '0;
            first_q <= 1'b0;
            slot_q  <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            frm_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            sreg_q  <= sreg_n;
            idx_q   <= idx_n;
            pix_q   <= pix_n;
            first_q <= first_n;
            slot_q  <= slot_n;
            cnt_q   <= cnt_n;
            vld_q   <= (cnt_n != '0);
            done_q  <= done_n;
            frm_q   <= frm_evt | (frm_q & ~clr_err);
            ovf_q   <= ovf_evt | (ovf_q & ~clr_err);
        end
    end

    assign bus.dout     = slot_q[0][SW-1:2];
    assign bus.dout_sop = slot_q[0][1];
    assign bus.dout_eop = slot_q[0][0];
    assign bus.dout_vld = vld_q;
    assign frame_done   = done_q;
    assign err_frm      = frm_q;
    assign err_ovf      = ovf_q;
endmodule

// File: tb/tb_edge_pix_pack.sv
// Testbench for edge_pix_pack: directed frames plus randomized traffic.
// A frame-level reference model (pixel queue per word, word counter for the
// FIFO) pushes expected words into a scoreboard; a separate monitor compares
// the DUT head word against it whenever dout_vld is high.
module tb_edge_pix_pack;
    localparam int W  = 16;
    localparam int D  = 4;
    localparam int FP = 32;
`ifdef PIX_INVERT_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic clk, rst, clr_err;
    logic frame_done, err_frm, err_ovf;

    edge_pix_pack_if #(.WORD_W(W)) bus();

    edge_pix_pack #(.WORD_W(W), .FIFO_DEPTH(D), .FRAME_PIX(FP)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .frame_done(frame_done),
        .err_frm   (err_frm),
        .err_ovf   (err_ovf),
        .clr_err   (clr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // reference model state
    bit           pend[$];
    logic [W+1:0] exp_q[$];
    bit           m_in, m_first, m_ferr, m_oerr, m_done;
    int           m_cnt, mocc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    task automatic post_checks();
        check("dout_vld", 32'(bus.dout_vld), 32'(mocc != 0));
        check("frame_done", 32'(frame_done), 32'(m_done));
        check("err_frm", 32'(err_frm), 32'(m_ferr));
        check("err_ovf", 32'(err_ovf), 32'(m_oerr));
    endtask

    // One clock: drive inputs, advance the model for this edge, check status.
    task automatic step(input bit v, input bit d, input bit s, input bit e,
                        input bit r, input bit c);
        bit           pop, have;
        logic [W+1:0] wv;
        logic [W-1:0] word;
        rst = 1'b0;
        bus.din_vld = v; bus.din = d; bus.din_sop = s; bus.din_eop = e;
        bus.dout_rdy = r; clr_err = c;

        pop    = (mocc > 0) && r;
        have   = 1'b0;
        wv     = '0;
        m_done = 1'b0;
        if (c) begin m_ferr = 1'b0; m_oerr = 1'b0; end
        if (v) begin
            if (!m_in && !s) begin
                m_ferr = 1'b1;
            end else begin
                if (s) begin
                    if (m_in) m_ferr = 1'b1;
                    pend.delete();
                    m_cnt = 0; m_first = 1'b1; m_in = 1'b1;
                end
                pend.push_back(d ^ INV);
                if (m_cnt < 24'hFF_FFFF) m_cnt++;
                if (pend.size() == W || e) begin
                    word = {W{INV}};
                    for (int k = 0; k < pend.size(); k++) word[W-1-k] = pend[k];
                    wv = {word, m_first, e};
                    have = 1'b1;
                    m_first = 1'b0;
                    pend.delete();
                    if (e) begin
                        m_in = 1'b0; m_done = 1'b1;
                        if (m_cnt != FP) m_ferr = 1'b1;
                    end
                end
            end
        end
        if (have && mocc == D && !pop) begin
            m_oerr = 1'b1;
            have = 1'b0;
        end else if (have) begin
            exp_q.push_back(wv);
        end
        mocc = mocc - int'(pop) + int'(have);

        @(posedge clk); #1;
        post_checks();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.din_vld = 1'b0; bus.din = 1'b0; bus.din_sop = 1'b0; bus.din_eop = 1'b0;
        bus.dout_rdy = 1'b1; clr_err = 1'b0;
        pend.delete(); exp_q.delete();
        m_in = 0; m_first = 0; m_ferr = 0; m_oerr = 0; m_done = 0; m_cnt = 0; mocc = 0;
        repeat (n) @(posedge clk);
        #1;
        post_checks();
        check("rst_dout", 32'({bus.dout, bus.dout_sop, bus.dout_eop}), 32'd0);
    endtask

    // pat: 0 = 1,0,1,0..., 1 = all ones, 2 = random
    task automatic send_frame(input int n, input int pat, input bit r);
        bit d;
        for (int i = 0; i < n; i++) begin
            d = (pat == 0) ? (i % 2 == 0) : (pat == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            step(1'b1, d, i == 0, i == n - 1, r, 1'b0);
        end
    endtask

    task automatic idle(input int n, input bit r);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, r, 1'b0);
    endtask

    // Scoreboard monitor: head word must match while valid; pop on transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && bus.dout_vld === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("dout_extra", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("dout", 32'({bus.dout, bus.dout_sop, bus.dout_eop}), 32'(exp_q[0]));
                    if (bus.dout_rdy === 1'b1) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        bit r, c;
        int len;
        rst = 1'b1;
        clr_err = 1'b0;
        bus.dout_rdy = 1'b1;
        bus.din_vld = 1'b0; bus.din = 1'b0; bus.din_sop = 1'b0; bus.din_eop = 1'b0;
        do_reset(3);

        // alternating 32-pixel frame: two 0xAAAA words
        send_frame(32, 0, 1'b1);
        idle(3, 1'b1);

        // 20 ones: 0xFFFF, 0xF000 (length error with FP=32)
        send_frame(20, 1, 1'b1);
        idle(3, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // single-pixel frame with sop=eop
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // overflow: stalled sink, 80 contiguous pixels, then drain and clear
        send_frame(80, 2, 1'b0);
        idle(4, 1'b0);
        idle(8, 1'b1);
        check("ovf_drained", 32'(exp_q.size()), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // short frame, then sop inside the next frame at pixel 5
        send_frame(10, 2, 1'b1);
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'($urandom_range(0, 1)), i == 0, 1'b0, 1'b1, 1'b0);
        send_frame(32, 2, 1'b1);
        idle(3, 1'b1);

        // gapped pixels, reset mid-word, clean frame afterwards
        for (int i = 0; i < 12; i++)
            step(i % 2 == 0, 1'($urandom_range(0, 1)), i == 0, 1'b0, 1'b1, 1'b0);
        do_reset(1);
        send_frame(32, 0, 1'b1);
        idle(3, 1'b1);

        // randomized traffic
        for (int f = 0; f < 40; f++) begin
            bit slow;
            slow = ($urandom_range(0, 4) == 0);
            len = ($urandom_range(0, 2) == 0) ? FP : int'($urandom_range(1, 40));
            if ($urandom_range(0, 7) == 0)
                step(1'b1, 1'b1, 1'b0, $urandom_range(0, 1) == 0, 1'b1, 1'b0);
            for (int i = 0; i < len; i++) begin
                while ($urandom_range(0, 2) == 0) begin
                    r = slow ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                    c = ($urandom_range(0, 19) == 0);
                    step(1'b0, 1'b0, 1'b0, 1'b0, r, c);
                end
                r = slow ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                c = ($urandom_range(0, 19) == 0);
                step(1'b1, 1'($urandom_range(0, 1)),
                     (i == 0) || ($urandom_range(0, 59) == 0), i == len - 1, r, c);
            end
        end

        idle(12, 1'b1);
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/edge_pix_pack.md
Name: edge_pix_pack

Overview:
- Consumer end of the 1-bit edge-pixel stream (din/din_vld/din_sop/din_eop) produced by the Sobel stage.
- Packs binary pixels, in raster order, into WORD_W-bit words with frame markers.
- Buffers words in a small FIFO and hands them to the frame-buffer writer over a valid/ready handshake.
- Flags framing errors and overflow; the upstream stream has no backpressure.

Parameters:
- WORD_W, 16, packed word width; power of two, 8..32.
- FIFO_DEPTH, 4, word FIFO depth; power of two, >=2.
- FRAME_PIX, 307200, expected pixels per frame, checked at eop.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- din  in  1  pixel value (1 = edge).
- din_vld  in  1  pixel valid.
- din_sop  in  1  first pixel of frame; qualified by din_vld.
- din_eop  in  1  last pixel of frame; qualified by din_vld.
- dout  out  WORD_W  packed word; first pixel in MSB.
- dout_vld  out  1  word available.
- dout_rdy  in  1  downstream accepts the word.
- dout_sop  out  1  word is the first of its frame.
- dout_eop  out  1  word is the last of its frame.
- frame_done  out  1  one-cycle pulse per completed frame.
- err_frm  out  1  sticky framing error.
- err_ovf  out  1  sticky FIFO overflow.
- clr_err  in  1  clears err_frm and err_ovf.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; FIFO empty; bit counter, pixel counter and shift register cleared. Reset mid-frame discards the partial word and all FIFO contents.
- FSM states IDLE and ACTIVE. Only cycles with din_vld=1 are processed.
- IDLE + sop: go to ACTIVE, pixel count = 1, bit index = 0, capture din; the next word pushed carries sop=1.
- IDLE + vld without sop: pixel dropped, err_frm set.
- ACTIVE + sop: err_frm set; partial word discarded; frame restarts with this pixel.
- sop and eop in the same beat: single-pixel frame; the word is pushed with sop=1 and eop=1.
- Packing: pixel k of a word goes to bit WORD_W-1-k. When bit index reaches WORD_W-1, the word is pushed that cycle and the index wraps to 0.
- eop with a partial word: unfilled LSBs are padded with 0, the word is pushed with eop=1, and the FSM returns to IDLE.
- eop when the pixel count != FRAME_PIX: err_frm set; the eop word is still pushed.
- Pixel counter saturates at 2^24-1.
- frame_done pulses exactly one cycle, in the cycle after the eop beat, even if that push overflowed.
- FIFO is first-word-fall-through. dout/dout_sop/dout_eop/dout_vld are registered; latency is 1 clk from the completing din_vld beat to dout_vld=1 (FIFO empty, rdy high).
- Transfer occurs on dout_vld & dout_rdy. While dout_vld=1 and dout_rdy=0, dout and its flags hold stable.
- Push when full without a simultaneous pop: the word is dropped and err_ovf set; if that word carried eop, the FSM still returns to IDLE.
- Push and pop in the same cycle when full: both succeed, no error.
- Push and pop on an empty FIFO: the word appears the following cycle (no bypass).
- clr_err clears both error flags that cycle. If an error event and clr_err coincide, the event wins (flag stays 1).

Optional Feature:
- PIX_INVERT_EN defined: each pixel is inverted before packing (edge = 0, background = 1). Pad bits become 1 instead of 0.
- PIX_INVERT_EN undefined: pixels are packed as received, pad bits are 0.

Test Plan:
- FRAME_PIX=32, WORD_W=16, rdy=1: 32 pixels, pattern 1 then 0 repeating, sop on pixel 0, eop on pixel 31 -> two words 0xAAAA; first sop=1 eop=0, second sop=0 eop=1; frame_done one pulse; no errors.
- FRAME_PIX=20: 20 ones with sop/eop -> words 0xFFFF then 0xF000 (eop=1); with PIX_INVERT_EN, 0x0000 then 0x0FFF.
- rdy=0, FIFO_DEPTH=4, 80 contiguous pixels -> first 4 words held stable, 5th dropped, err_ovf=1; then rdy=1 -> exactly 4 words drained; clr_err -> err_ovf=0.
- Frame of 10 pixels with FRAME_PIX=32 -> one word, eop=1, err_frm=1; sop at pixel 5 of the next frame -> err_frm stays set and a fresh frame starts.
- Single beat with sop=eop=1, din=1 -> one word 0x8000, sop=1, eop=1; frame_done pulse.
- din_vld toggling every other cycle plus assertion of rst mid-word -> outputs 0 next cycle; a subsequent clean 32-pixel frame packs correctly.
